// File: rtl/mem_data_controller_if.sv
// Word-addressed, byte-enabled data memory handshake between the MEM-stage
// controller (master) and the data memory (slave).
interface mem_data_controller_if;
    logic [29:0] DataMem_Address;
    logic        DataMem_Read;
    logic [3:0]  DataMem_Write;
    logic [31:0] DataMem_Out;
    logic [31:0] DataMem_In;
    logic        DataMem_Ready;

    modport master (
        output DataMem_Address, DataMem_Read, DataMem_Write, DataMem_Out,
        input  DataMem_In, DataMem_Ready
    );

    modport slave (
        input  DataMem_Address, DataMem_Read, DataMem_Write, DataMem_Out,
        output DataMem_In, DataMem_Ready
    );
endinterface

// File: rtl/mem_data_controller.sv
// MEM-stage data memory controller: load/store/LL/SC handshake with big-endian
// lane steering, load extension, alignment exceptions and pipeline stall request.
module mem_data_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        Byte,
    input  logic        Half,
    input  logic        SignExtend,
    input  logic        LL,
    input  logic        SC,
    input  logic        Eret,
    input  logic        IF_Stall,
    input  logic        Flush,
    output logic [31:0] DataOut,
    output logic        M_Stall,
    output logic        EXC_AdEL,
    output logic        EXC_AdES,
    mem_data_controller_if.master mem
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state;
    logic        llsc;
    logic [29:0] llsc_addr;
    logic        r_byte, r_half, r_sign, r_ll, r_sc;
    logic [1:0]  r_off;

    logic        misaligned, req, sc_ok, start, sc_fail;
    logic [3:0]  we_lanes;
    logic [31:0] wr_data;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_value;

    always_comb begin
        misaligned = 1'b0;
        if (Byte)      misaligned = 1'b0;
        else if (Half) misaligned = Address[0];
        else           misaligned = |Address[1:0];
    end

    assign EXC_AdEL = MemRead & misaligned;
    assign EXC_AdES = MemWrite & misaligned;
    assign req      = (MemRead | MemWrite) & ~Flush;
    assign sc_ok    = llsc & (llsc_addr == Address[31:2]);
    // A failing SC never touches memory, so it must not raise the stall either.
    assign start    = (state == IDLE) & req & ~misaligned & ~(SC & ~sc_ok);
    assign sc_fail  = (state == IDLE) & req & ~misaligned & SC & ~sc_ok;
    assign M_Stall  = start | (state == ACCESS);

    always_comb begin
        we_lanes = 4'b1111;
        wr_data  = DataIn;
        if (Byte) begin
            we_lanes = 4'b1000 >> Address[1:0];
            wr_data  = {4{DataIn[7:0]}};
        end else if (Half) begin
            we_lanes = Address[1] ? 4'b0011 : 4'b1100;
            wr_data  = {2{DataIn[15:0]}};
        end
    end

    always_comb begin
        rd_byte = '0;
        case (r_off)
            2'd0:    rd_byte = mem.DataMem_In[31:24];
            2'd1:    rd_byte = mem.DataMem_In[23:16];
            2'd2:    rd_byte = mem.DataMem_In[15:8];
            default: rd_byte = mem.DataMem_In[7:0];
        endcase
        rd_half = r_off[1] ? mem.DataMem_In[15:0] : mem.DataMem_In[31:16];
        if (r_byte)      load_value = {{24{r_sign & rd_byte[7]}}, rd_byte};
        else if (r_half) load_value = {{16{r_sign & rd_half[15]}}, rd_half};
        else             load_value = mem.DataMem_In;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            DataOut             <= '0;
            mem.DataMem_Address <= '0;
            mem.DataMem_Read    <= 1'b0;
            mem.DataMem_Write   <= '0;
            mem.DataMem_Out     <= '0;
            llsc                <= 1'b0;
            llsc_addr           <= '0;
            r_byte              <= 1'b0;
            r_half              <= 1'b0;
            r_sign              <= 1'b0;
            r_ll                <= 1'b0;
            r_sc                <= 1'b0;
            r_off               <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state               <= ACCESS;
                        mem.DataMem_Address <= Address[31:2];
                        mem.DataMem_Read    <= MemRead;
                        mem.DataMem_Write   <= MemWrite ? we_lanes : 4'b0000;
                        mem.DataMem_Out     <= wr_data;
                        r_byte              <= Byte;
                        r_half              <= Half;
                        r_sign              <= SignExtend;
                        r_ll                <= LL;
                        r_sc                <= SC;
                        r_off               <= Address[1:0];
                    end else if (sc_fail) begin
                        state   <= DONE;
                        DataOut <= '0;
                        llsc    <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (mem.DataMem_Ready) begin
                        state             <= DONE;
                        mem.DataMem_Read  <= 1'b0;
                        mem.DataMem_Write <= '0;
                        if (r_sc) begin
                            DataOut <= 32'd1;
                            llsc    <= 1'b0;
                        end else if (mem.DataMem_Read) begin
                            DataOut <= load_value;
                            if (r_ll) begin
                                llsc      <= 1'b1;
                                llsc_addr <= mem.DataMem_Address;
                            end
                        end
                    end
                end
                DONE: begin
                    if (!IF_Stall) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Placed last so Eret overrides an LL completing in the same cycle.
            if (Eret) llsc <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_data_controller.sv
// Directed self-checking bench for mem_data_controller.
module tb_mem_data_controller;
    logic        clock, reset;
    logic [31:0] Address, DataIn;
    logic        MemRead, MemWrite, Byte, Half, SignExtend, LL, SC, Eret, IF_Stall, Flush;
    logic [31:0] DataOut;
    logic        M_Stall, EXC_AdEL, EXC_AdES;
    int          n_checks = 0;
    int          n_fail = 0;

    mem_data_controller_if mem ();

    mem_data_controller dut (
        .clock(clock), .reset(reset), .Address(Address), .DataIn(DataIn),
        .MemRead(MemRead), .MemWrite(MemWrite), .Byte(Byte), .Half(Half),
        .SignExtend(SignExtend), .LL(LL), .SC(SC), .Eret(Eret),
        .IF_Stall(IF_Stall), .Flush(Flush), .DataOut(DataOut), .M_Stall(M_Stall),
        .EXC_AdEL(EXC_AdEL), .EXC_AdES(EXC_AdES), .mem(mem.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic clear_inputs;
        Address = '0; DataIn = '0; MemRead = 0; MemWrite = 0; Byte = 0; Half = 0;
        SignExtend = 0; LL = 0; SC = 0; Eret = 0; IF_Stall = 0; Flush = 0;
    endtask

    // Runs one MEM instruction from IDLE to the return to IDLE, pulsing Ready
    // wait_cycles after the first strobe cycle and holding IF_Stall in DONE.
    task automatic do_access(input int wait_cycles, input int hold, input logic [31:0] rdata,
                             output int stalls, output int strobes, output logic rd,
                             output logic [3:0] we, output logic [31:0] wd,
                             output logic [29:0] wa, output logic [31:0] done_data,
                             output logic unstable);
        int  held;
        bit  fin;
        stalls = 0; strobes = 0; rd = 0; we = '0; wd = '0; wa = '0;
        done_data = '0; unstable = 0; held = 0; fin = 0;
        mem.DataMem_In = rdata;
        for (int c = 0; c < 40 && !fin; c++) begin
            mem.DataMem_Ready = (c == wait_cycles + 1);
            #1;
            if (M_Stall) stalls++;
            if (mem.DataMem_Read || mem.DataMem_Write != 4'b0000) begin
                strobes++;
                rd = mem.DataMem_Read; we = mem.DataMem_Write;
                wd = mem.DataMem_Out;  wa = mem.DataMem_Address;
            end
            if (c > 0 && !M_Stall) begin
                if (held == 0) done_data = DataOut;
                else if (DataOut !== done_data) unstable = 1;
                if (held < hold) begin
                    IF_Stall = 1; held++;
                end else begin
                    IF_Stall = 0; MemRead = 0; MemWrite = 0; LL = 0; SC = 0; fin = 1;
                end
            end
            @(posedge clock); #1;
        end
        mem.DataMem_Ready = 0;
        n_checks++;
        if (!fin) begin n_fail++; $display("FAIL access_timeout: completed=%0d required=1", fin); end
    endtask

    task automatic test_reset;
        clear_inputs();
        mem.DataMem_In = '0; mem.DataMem_Ready = 0;
        reset = 0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if (DataOut !== 32'h0) begin n_fail++; $display("FAIL rst_dataout: got %h want 0", DataOut); end
        n_checks++; if (mem.DataMem_Read !== 1'b0 || mem.DataMem_Write !== 4'h0) begin n_fail++; $display("FAIL rst_strobes: got %b/%b want 0/0000", mem.DataMem_Read, mem.DataMem_Write); end
        n_checks++; if (mem.DataMem_Address !== 30'h0 || mem.DataMem_Out !== 32'h0) begin n_fail++; $display("FAIL rst_addr_out: got %h/%h want 0/0", mem.DataMem_Address, mem.DataMem_Out); end
        n_checks++; if (M_Stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", M_Stall); end
        @(negedge clock); reset = 1;
        @(posedge clock); #1;
    endtask

    task automatic test_load_word;
        int s, st; logic rd, un; logic [3:0] we; logic [31:0] wd, dd; logic [29:0] wa;
        clear_inputs(); Address = 32'h100; MemRead = 1;
        do_access(2, 0, 32'hDEADBEEF, s, st, rd, we, wd, wa, dd, un);
        n_checks++; if (wa !== 30'h40) begin n_fail++; $display("FAIL lw_addr: got %h want 40", wa); end
        n_checks++; if (s !== 4) begin n_fail++; $display("FAIL lw_stall_cycles: got %0d want 4", s); end
        n_checks++; if (st !== 3 || rd !== 1'b1) begin n_fail++; $display("FAIL lw_strobe: got %0d cycles rd=%b want 3 rd=1", st, rd); end
        n_checks++; if (dd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h want deadbeef", dd); end
        n_checks++; if (DataOut !== 32'hDEADBEEF || M_Stall !== 1'b0) begin n_fail++; $display("FAIL lw_idle: got %h stall=%b want deadbeef stall=0", DataOut, M_Stall); end
    endtask

    task automatic test_store_lanes;
        int s, st; logic rd, un; logic [3:0] we; logic [31:0] wd, dd; logic [29:0] wa;
        clear_inputs(); Address = 32'h103; DataIn = 32'h000000A5; MemWrite = 1; Byte = 1;
        #1;
        n_checks++; if (EXC_AdES !== 1'b0) begin n_fail++; $display("FAIL sb_no_exc: got %b want 0", EXC_AdES); end
        do_access(0, 0, 32'h0, s, st, rd, we, wd, wa, dd, un);
        n_checks++; if (we !== 4'b0001) begin n_fail++; $display("FAIL sb_we: got %b want 0001", we); end
        n_checks++; if (wd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h want a5a5a5a5", wd); end
        n_checks++; if (st !== 1 || s !== 2) begin n_fail++; $display("FAIL sb_single: got strobes=%0d stalls=%0d want 1/2", st, s); end
        n_checks++; if (mem.DataMem_Write !== 4'h0 || M_Stall !== 1'b0) begin n_fail++; $display("FAIL sb_idle: got we=%b stall=%b want 0000/0", mem.DataMem_Write, M_Stall); end
        clear_inputs(); Address = 32'h6; DataIn = 32'h1234BEEF; MemWrite = 1; Half = 1;
        do_access(1, 0, 32'h0, s, st, rd, we, wd, wa, dd, un);
        n_checks++; if (we !== 4'b0011 || wd !== 32'hBEEFBEEF) begin n_fail++; $display("FAIL sh_lanes: got %b/%h want 0011/beefbeef", we, wd); end
    endtask

    task automatic test_load_extend;
        int s, st; logic rd, un; logic [3:0] we; logic [31:0] wd, dd; logic [29:0] wa;
        clear_inputs(); Address = 32'h2; MemRead = 1; Half = 1; SignExtend = 1;
        do_access(0, 0, 32'h12348001, s, st, rd, we, wd, wa, dd, un);
        n_checks++; if (dd !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_signed: got %h want ffff8001", dd); end
        clear_inputs(); Address = 32'h2; MemRead = 1; Half = 1;
        do_access(0, 0, 32'h12348001, s, st, rd, we, wd, wa, dd, un);
        n_checks++; if (dd !== 32'h00008001) begin n_fail++; $display("FAIL lhu: got %h want 00008001", dd); end
        clear_inputs(); Address = 32'h1; MemRead = 1; Byte = 1; SignExtend = 1;
        do_access(0, 0, 32'h12F40000, s, st, rd, we, wd, wa, dd, un);
        n_checks++; if (dd !== 32'hFFFFFFF4) begin n_fail++; $display("FAIL lb_signed: got %h want fffffff4", dd); end
    endtask

    task automatic test_ll_sc;
        int s, st; logic rd, un; logic [3:0] we; logic [31:0] wd, dd; logic [29:0] wa;
        clear_inputs(); Address = 32'h200; MemRead = 1; LL = 1;
        do_access(0, 0, 32'h00000055, s, st, rd, we, wd, wa, dd, un);
        clear_inputs(); Address = 32'h200; MemWrite = 1; SC = 1; DataIn = 32'hCAFEF00D;
        do_access(0, 0, 32'h0, s, st, rd, we, wd, wa, dd, un);
        n_checks++; if (dd !== 32'd1 || we !== 4'b1111 || wd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL sc_ok: got %h/%b/%h want 1/1111/cafef00d", dd, we, wd); end
        clear_inputs(); Address = 32'h200; MemRead = 1; LL = 1;
        do_access(0, 0, 32'h00000077, s, st, rd, we, wd, wa, dd, un);
        clear_inputs(); Eret = 1; @(posedge clock); #1; Eret = 0;
        Address = 32'h200; MemWrite = 1; SC = 1; DataIn = 32'h11111111;
        do_access(0, 0, 32'h0, s, st, rd, we, wd, wa, dd, un);
        n_checks++; if (dd !== 32'd0 || st !== 0 || s !== 0) begin n_fail++; $display("FAIL sc_after_eret: got %h strobes=%0d stalls=%0d want 0/0/0", dd, st, s); end
        clear_inputs(); Address = 32'h200; MemRead = 1; LL = 1; Eret = 1;
        do_access(0, 0, 32'h00000099, s, st, rd, we, wd, wa, dd, un);
        clear_inputs(); Address = 32'h200; MemWrite = 1; SC = 1;
        do_access(0, 0, 32'h0, s, st, rd, we, wd, wa, dd, un);
        n_checks++; if (dd !== 32'd0 || st !== 0) begin n_fail++; $display("FAIL eret_beats_ll: got %h strobes=%0d want 0/0", dd, st); end
    endtask

    task automatic test_misaligned;
        clear_inputs(); Address = 32'h102; MemRead = 1;
        #1;
        n_checks++; if (EXC_AdEL !== 1'b1 || EXC_AdES !== 1'b0 || M_Stall !== 1'b0) begin n_fail++; $display("FAIL lw_misaligned: got adel=%b ades=%b stall=%b want 1/0/0", EXC_AdEL, EXC_AdES, M_Stall); end
        @(posedge clock); #1;
        n_checks++; if (mem.DataMem_Read !== 1'b0) begin n_fail++; $display("FAIL lw_misaligned_strobe: got %b want 0", mem.DataMem_Read); end
        clear_inputs(); Address = 32'h1; MemWrite = 1; Half = 1;
        #1;
        n_checks++; if (EXC_AdES !== 1'b1 || EXC_AdEL !== 1'b0 || M_Stall !== 1'b0) begin n_fail++; $display("FAIL sh_misaligned: got ades=%b adel=%b stall=%b want 1/0/0", EXC_AdES, EXC_AdEL, M_Stall); end
        @(posedge clock); #1;
        n_checks++; if (mem.DataMem_Write !== 4'h0) begin n_fail++; $display("FAIL sh_misaligned_strobe: got %b want 0000", mem.DataMem_Write); end
        clear_inputs(); Address = 32'h100; MemRead = 1; Flush = 1;
        #1;
        n_checks++; if (M_Stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", M_Stall); end
        @(posedge clock); #1;
        n_checks++; if (mem.DataMem_Read !== 1'b0) begin n_fail++; $display("FAIL flush_strobe: got %b want 0", mem.DataMem_Read); end
        clear_inputs(); @(posedge clock); #1;
    endtask

    task automatic test_if_stall_hold;
        int s, st; logic rd, un; logic [3:0] we; logic [31:0] wd, dd; logic [29:0] wa;
        clear_inputs(); Address = 32'h8; MemRead = 1;
        do_access(0, 3, 32'h13579BDF, s, st, rd, we, wd, wa, dd, un);
        n_checks++; if (st !== 1) begin n_fail++; $display("FAIL hold_no_reissue: got %0d strobes want 1", st); end
        n_checks++; if (un !== 1'b0 || dd !== 32'h13579BDF) begin n_fail++; $display("FAIL hold_dataout: got %h unstable=%b want 13579bdf/0", dd, un); end
    endtask

    task automatic test_reset_mid_access;
        int s, st; logic rd, un; logic [3:0] we; logic [31:0] wd, dd; logic [29:0] wa;
        clear_inputs(); Address = 32'h40; MemRead = 1;
        @(posedge clock); #1;
        n_checks++; if (mem.DataMem_Read !== 1'b1) begin n_fail++; $display("FAIL mid_rst_pre: got %b want 1", mem.DataMem_Read); end
        #2 reset = 0;
        #1;
        n_checks++; if (mem.DataMem_Read !== 1'b0 || mem.DataMem_Write !== 4'h0) begin n_fail++; $display("FAIL mid_rst_strobes: got %b/%b want 0/0000", mem.DataMem_Read, mem.DataMem_Write); end
        MemRead = 0;
        #1;
        n_checks++; if (M_Stall !== 1'b0 || DataOut !== 32'h0) begin n_fail++; $display("FAIL mid_rst_idle: got stall=%b data=%h want 0/0", M_Stall, DataOut); end
        @(negedge clock); reset = 1;
        @(posedge clock); #1;
        clear_inputs(); Address = 32'hC; MemRead = 1;
        do_access(0, 0, 32'h2468ACE0, s, st, rd, we, wd, wa, dd, un);
        n_checks++; if (s !== 2 || dd !== 32'h2468ACE0) begin n_fail++; $display("FAIL post_rst_access: got stalls=%0d data=%h want 2/2468ace0", s, dd); end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_store_lanes();
        test_load_extend();
        test_ll_sc();
        test_misaligned();
        test_if_stall_hold();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
